// File: rtl/fft_seq_pkg.sv
// Shared types and helpers for the FFT frame sequencer.
package fft_seq_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        CONFIG = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    localparam logic CFG_FWD = 1'b1;
    localparam logic CFG_INV = 1'b0;

    // Config word carries only the direction bit in its LSB.
    function automatic logic [31:0] cfg_word(input logic d);
        return {31'b0, d};
    endfunction

endpackage

// File: rtl/fft_frame_buffer.sv
// Frame storage: DATA_W x DEPTH registers with a per-entry valid mask.
// Entries never written since the last clear read back as zero.
module fft_frame_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              aclk,
    input  logic              clr,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  vmask;

    always_ff @(posedge aclk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge aclk) begin
        if (clr)
            vmask <= '0;
        else if (we)
            vmask[waddr] <= 1'b1;
    end

    assign rdata = vmask[raddr] ? mem[raddr] : '0;

endmodule

// File: rtl/fft_frame_sequencer.sv
// Collects one frame from upstream, issues the FFT config word when needed,
// then plays the frame to the FFT forward or reversed with in_last on the end.
module fft_frame_sequencer
    import fft_seq_pkg::*;
#(
    parameter int DATA_W          = 32,
    parameter int FRAME_LEN       = 16,
    parameter int CFG_W           = 8,
    parameter int CFG_EVERY_FRAME = 1,
    parameter int CNT_W           = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    input  logic              dir,
    input  logic              reverse_order,
    output logic [CFG_W-1:0]  config_data,
    output logic              config_valid,
    input  logic              config_ready,
    output logic [DATA_W-1:0] in_data,
    output logic              in_valid,
    output logic              in_last,
    input  logic              in_ready,
    output logic              busy,
    output logic              frame_err,
    output logic [CNT_W-1:0]  frame_count
);

    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);

    state_t           state;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] out_cnt;
    logic             dir_lat;
    logic             rev_lat;
    logic             cfg_sent;
    logic             sent_dir;

    logic s_hs;
    logic close;
    logic early;
    logic need_cfg;
    logic in_hs;
    logic drain_done;

    assign s_hs       = s_valid && s_ready;
    assign early      = s_last && (wr_idx != LAST_IDX);
    assign close      = s_hs && ((wr_idx == LAST_IDX) || s_last);
    assign need_cfg   = (CFG_EVERY_FRAME != 0) || !cfg_sent || (dir != sent_dir);
    assign in_hs      = in_valid && in_ready;
    assign drain_done = in_hs && in_last;

    assign s_ready      = (state == FILL);
    assign config_valid = (state == CONFIG);
    assign in_valid     = (state == DRAIN);
    assign in_last      = (state == DRAIN) && (out_cnt == LAST_IDX);
    assign busy         = (state == CONFIG) || (state == DRAIN);
    assign config_data  = CFG_W'(cfg_word(dir_lat));

    // Mask clear on reset and on leaving DRAIN, so a short frame pads with zeros.
    fft_frame_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (FRAME_LEN),
        .IDX_W  (IDX_W)
    ) u_buf (
        .aclk  (aclk),
        .clr   (!aresetn || drain_done),
        .we    (s_hs),
        .waddr (wr_idx),
        .wdata (s_data),
        .raddr (rd_idx),
        .rdata (in_data)
    );

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state       <= FILL;
            wr_idx      <= '0;
            rd_idx      <= '0;
            out_cnt     <= '0;
            dir_lat     <= CFG_INV;
            rev_lat     <= 1'b0;
            cfg_sent    <= 1'b0;
            sent_dir    <= CFG_INV;
            frame_err   <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                FILL: begin
                    if (s_hs) begin
                        wr_idx <= wr_idx + ONE;
                        if (close) begin
                            dir_lat   <= dir;
                            rev_lat   <= reverse_order;
                            frame_err <= early;
                            rd_idx    <= reverse_order ? LAST_IDX : '0;
                            out_cnt   <= '0;
                            state     <= need_cfg ? CONFIG : DRAIN;
                        end
                    end
                end
                CONFIG: begin
                    if (config_ready) begin
                        cfg_sent <= 1'b1;
                        sent_dir <= dir_lat;
                        state    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (in_hs) begin
                        out_cnt <= out_cnt + ONE;
                        rd_idx  <= rev_lat ? rd_idx - ONE : rd_idx + ONE;
                        if (in_last) begin
                            frame_count <= frame_count + CNT_W'(1);
                            wr_idx      <= '0;
                            state       <= FILL;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench: table of frame scenarios plus hand sequences for config
// stall, mid-drain reset and config-on-change mode.
module tb_fft_frame_sequencer;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] s_data;
    logic        s_valid, s_last, s_ready;
    logic        dir, reverse_order;
    logic [7:0]  config_data;
    logic        config_valid, config_ready;
    logic [31:0] in_data;
    logic        in_valid, in_last, in_ready;
    logic        busy, frame_err;
    logic [15:0] frame_count;

    logic [31:0] b_s_data;
    logic        b_s_valid, b_s_last, b_s_ready;
    logic        b_dir, b_reverse_order;
    logic [7:0]  b_config_data;
    logic        b_config_valid, b_config_ready;
    logic [31:0] b_in_data;
    logic        b_in_valid, b_in_last, b_in_ready;
    logic        b_busy, b_frame_err;
    logic [15:0] b_frame_count;

    always #5 aclk = ~aclk;

    fft_frame_sequencer #(.DATA_W(32), .FRAME_LEN(16), .CFG_W(8), .CFG_EVERY_FRAME(1), .CNT_W(16)) dut (
        .aclk(aclk), .aresetn(aresetn), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .dir(dir), .reverse_order(reverse_order), .config_data(config_data),
        .config_valid(config_valid), .config_ready(config_ready), .in_data(in_data),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready), .busy(busy),
        .frame_err(frame_err), .frame_count(frame_count));

    fft_frame_sequencer #(.DATA_W(32), .FRAME_LEN(16), .CFG_W(8), .CFG_EVERY_FRAME(0), .CNT_W(16)) dut_b (
        .aclk(aclk), .aresetn(aresetn), .s_data(b_s_data), .s_valid(b_s_valid), .s_last(b_s_last),
        .s_ready(b_s_ready), .dir(b_dir), .reverse_order(b_reverse_order), .config_data(b_config_data),
        .config_valid(b_config_valid), .config_ready(b_config_ready), .in_data(b_in_data),
        .in_valid(b_in_valid), .in_last(b_in_last), .in_ready(b_in_ready), .busy(b_busy),
        .frame_err(b_frame_err), .frame_count(b_frame_count));

    int n_pass = 0;
    int n_total = 0;

    logic [7:0]  cfg_q[$];
    logic [32:0] out_q[$];
    logic [7:0]  b_cfg_q[$];
    int          err_cnt = 0;

    logic        hold_v = 1'b0;
    logic [32:0] hold_w;
    logic        cfg_hold = 1'b0;
    logic [7:0]  cfg_hold_d;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    endtask

    // Inputs change 1ns after posedge; observation is on the negedge.
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    always @(negedge aclk) begin
        if (aresetn) begin
            if (config_valid && config_ready) cfg_q.push_back(config_data);
            if (in_valid && in_ready) out_q.push_back({in_last, in_data});
            if (frame_err) err_cnt++;
            if (b_config_valid && b_config_ready) b_cfg_q.push_back(b_config_data);
        end
        if (hold_v) chk("stall_stable", 64'({in_valid, in_last, in_data}), 64'({1'b1, hold_w}));
        if (cfg_hold) chk("cfg_stable", 64'({config_valid, config_data}), 64'({1'b1, cfg_hold_d}));
        hold_v     = aresetn && in_valid && !in_ready;
        hold_w     = {in_last, in_data};
        cfg_hold   = aresetn && config_valid && !config_ready;
        cfg_hold_d = config_data;
    end

    function automatic logic [31:0] sample(input logic [31:0] base, input int i);
        return base + 32'(i) * 32'h0101_0101;
    endfunction

    task automatic push(input logic [31:0] d, input logic l);
        int t;
        s_data = d; s_last = l; s_valid = 1'b1;
        t = 0;
        while (!s_ready && t < 500) begin step(); t++; end
        if (t >= 500) chk("push_timeout", 64'(t), 64'(0));
        step();
    endtask

    task automatic send_frame(input logic [31:0] base, input int n, input bit use_last);
        for (int i = 0; i < n; i++) push(sample(base, i), use_last && (i == n - 1));
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic run_drain(input int n, input bit stall);
        int t;
        t = 0;
        while (out_q.size() < n && t < 2000) begin
            in_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            t++;
        end
        if (t >= 2000) chk("drain_timeout", 64'(out_q.size()), 64'(n));
        in_ready = 1'b1;
    endtask

    task automatic check_outputs(input string nm, input logic [31:0] base, input int n, input bit rev);
        int idx;
        logic [31:0] ev;
        chk({nm, "_count"}, 64'(out_q.size()), 64'(16));
        for (int k = 0; k < 16 && k < out_q.size(); k++) begin
            idx = rev ? 15 - k : k;
            ev  = (idx < n) ? sample(base, idx) : 32'h0;
            chk(nm, 64'(out_q[k]), 64'({(k == 15), ev}));
        end
    endtask

    task automatic check_reset_vals(input string nm);
        chk({nm, "_s_ready"}, 64'(s_ready), 64'(1));
        chk({nm, "_cfg_valid"}, 64'(config_valid), 64'(0));
        chk({nm, "_in_valid"}, 64'(in_valid), 64'(0));
        chk({nm, "_in_last"}, 64'(in_last), 64'(0));
        chk({nm, "_frame_err"}, 64'(frame_err), 64'(0));
        chk({nm, "_busy"}, 64'(busy), 64'(0));
        chk({nm, "_frame_count"}, 64'(frame_count), 64'(0));
    endtask

    typedef struct {
        bit          rev;
        int          n;
        bit          use_last;
        bit          stall;
        bit          dir;
        logic [31:0] base;
        logic [7:0]  exp_cfg;
        int          exp_err;
    } vec_t;

    vec_t tbl[5];

    initial begin
        tbl[0] = '{rev: 1'b0, n: 16, use_last: 1'b1, stall: 1'b0, dir: 1'b1, base: 32'h3F3E_3EBD, exp_cfg: 8'h01, exp_err: 0};
        tbl[1] = '{rev: 1'b1, n: 16, use_last: 1'b0, stall: 1'b0, dir: 1'b1, base: 32'h3F3E_3EBD, exp_cfg: 8'h01, exp_err: 0};
        tbl[2] = '{rev: 1'b0, n: 16, use_last: 1'b0, stall: 1'b1, dir: 1'b0, base: 32'h2500_1100, exp_cfg: 8'h00, exp_err: 0};
        tbl[3] = '{rev: 1'b0, n: 5,  use_last: 1'b1, stall: 1'b0, dir: 1'b1, base: 32'h4120_0000, exp_cfg: 8'h01, exp_err: 1};
        tbl[4] = '{rev: 1'b1, n: 5,  use_last: 1'b1, stall: 1'b1, dir: 1'b0, base: 32'hC0A0_0000, exp_cfg: 8'h00, exp_err: 1};

        aresetn = 1'b0;
        s_data = '0; s_valid = 1'b0; s_last = 1'b0; dir = 1'b1; reverse_order = 1'b0;
        config_ready = 1'b1; in_ready = 1'b1;
        b_s_data = '0; b_s_valid = 1'b0; b_s_last = 1'b0; b_dir = 1'b1; b_reverse_order = 1'b0;
        b_config_ready = 1'b1; b_in_ready = 1'b1;
        repeat (3) step();
        check_reset_vals("rst");
        aresetn = 1'b1;
        step();

        // Config only on first frame and on direction change.
        for (int f = 0; f < 3; f++) begin
            int t;
            b_dir = (f < 2);
            for (int i = 0; i < 16; i++) begin
                b_s_data = 32'(i); b_s_valid = 1'b1;
                t = 0;
                while (!b_s_ready && t < 500) begin step(); t++; end
                step();
            end
            b_s_valid = 1'b0;
            t = 0;
            while (b_frame_count != 16'(f + 1) && t < 500) begin step(); t++; end
            chk("b_frame_done", 64'(b_frame_count), 64'(f + 1));
        end
        chk("b_cfg_cnt", 64'(b_cfg_q.size()), 64'(2));
        if (b_cfg_q.size() == 2) begin
            chk("b_cfg0", 64'(b_cfg_q[0]), 64'h01);
            chk("b_cfg1", 64'(b_cfg_q[1]), 64'h00);
        end

        for (int r = 0; r < 5; r++) begin
            cfg_q.delete(); out_q.delete(); err_cnt = 0;
            dir = tbl[r].dir; reverse_order = tbl[r].rev;
            send_frame(tbl[r].base, tbl[r].n, tbl[r].use_last);
            // Changes after close must not affect the frame in flight.
            dir = ~tbl[r].dir; reverse_order = ~tbl[r].rev;
            run_drain(16, tbl[r].stall);
            chk("cfg_cnt", 64'(cfg_q.size()), 64'(1));
            if (cfg_q.size() == 1) chk("cfg_word", 64'(cfg_q[0]), 64'(tbl[r].exp_cfg));
            check_outputs("vec_data", tbl[r].base, tbl[r].n, tbl[r].rev);
            chk("vec_err", 64'(err_cnt), 64'(tbl[r].exp_err));
            chk("vec_fcount", 64'(frame_count), 64'(r + 1));
            chk("vec_s_ready", 64'(s_ready), 64'(1));
        end

        // Config held off, then reset during DRAIN.
        cfg_q.delete(); out_q.delete();
        dir = 1'b1; reverse_order = 1'b0; config_ready = 1'b0; in_ready = 1'b0;
        send_frame(32'h1234_0000, 16, 1'b0);
        chk("cfg_latency", 64'({config_valid, busy}), 64'(2'b11));
        repeat (20) step();
        chk("cfg_held", 64'({config_valid, config_data}), 64'({1'b1, 8'h01}));
        config_ready = 1'b1;
        step();
        config_ready = 1'b0;
        step();
        chk("in_valid_after_cfg", 64'({config_valid, in_valid}), 64'(2'b01));
        step();
        aresetn = 1'b0;
        step();
        step();
        check_reset_vals("mid_rst");
        chk("no_out_aborted", 64'(out_q.size()), 64'(0));
        aresetn = 1'b1;
        config_ready = 1'b1; in_ready = 1'b1;
        step();
        cfg_q.delete(); out_q.delete();
        send_frame(32'h5555_0001, 16, 1'b0);
        run_drain(16, 1'b0);
        check_outputs("post_rst", 32'h5555_0001, 16, 1'b0);
        chk("post_rst_fcount", 64'(frame_count), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fft_frame_sequencer.md
Name: fft_frame_sequencer

Overview:
Parametrised frame feeder in front of the FFT wrapper. It collects FRAME_LEN samples from an upstream valid/ready source into a local frame buffer, issues the FFT config transaction, then streams the frame to the FFT with in_last on the final sample. Over the fixed single-frame scheme it adds generic width and depth, forward or reversed playback order, selectable config-per-frame, short-frame zero padding, and frame counting.

Parameters:
DATA_W, 32, sample width (IEEE-754 single by default)
FRAME_LEN, 16, samples per frame; power of two, 2..1024
CFG_W, 8, FFT config word width
CFG_EVERY_FRAME, 1, 1: config before every frame; 0: only on first frame after reset or when dir changes
CNT_W, 16, frame counter width

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
s_data  in  DATA_W  upstream sample
s_valid  in  1  upstream sample valid
s_last  in  1  upstream end of frame (optional; early assertion truncates the frame)
s_ready  out  1  buffer accepting samples
dir  in  1  1 forward FFT, 0 inverse; sampled at frame close
reverse_order  in  1  1: play buffer from index FRAME_LEN-1 down to 0; sampled at frame close
config_data  out  CFG_W  {zeros, dir_latched}
config_valid  out  1  config request
config_ready  in  1  FFT accepts config
in_data  out  DATA_W  sample to FFT
in_valid  out  1  sample valid
in_last  out  1  final sample of frame
in_ready  in  1  FFT accepts sample
busy  out  1  high in CONFIG or DRAIN
frame_err  out  1  one-cycle pulse on early s_last
frame_count  out  CNT_W  frames completely drained; wraps

Behaviour:
- One clock: aclk. Reset is synchronous and active-low on aresetn. All registers update on the rising edge of aclk.
- Reset values: state=FILL, wr_idx=0, rd_idx=0, s_ready=1, config_valid=0, in_valid=0, in_last=0, frame_err=0, frame_count=0, busy=0, cfg_sent=0. Buffer contents are undefined.
- Reset asserted mid-frame aborts the frame. No in_last is produced for the aborted frame, and its partial data is discarded.
- FILL: s_ready=1. A handshake (s_valid&&s_ready) writes buf[wr_idx] and increments wr_idx.
  - Frame closes on the handshake where wr_idx==FRAME_LEN-1, or on an s_last handshake with wr_idx<FRAME_LEN-1.
  - On an early close, frame_err pulses for one cycle. Locations wr_idx+1..FRAME_LEN-1 read as zero during drain; a per-entry valid mask is cleared at FILL entry.
  - s_last on the final sample is normal, with no error. Missing s_last is not an error.
  - At close, latch dir and reverse_order, then go to CONFIG if config is needed, else DRAIN.
- CONFIG is needed when CFG_EVERY_FRAME=1, when cfg_sent=0, or when the latched dir differs from the last sent dir.
- CONFIG: config_valid=1 and config_data stays stable until config_ready. On the handshake, set cfg_sent=1, store the sent dir, and go to DRAIN next cycle. s_ready=0.
- DRAIN: s_ready=0, in_valid=1.
  - rd_idx starts at 0 (forward) or FRAME_LEN-1 (reversed). in_data=buf[rd_idx], masked to zero if the entry is not valid.
  - in_data and in_last are held stable while in_valid&&!in_ready.
  - Each in_valid&&in_ready handshake steps rd_idx by +1 or -1.
  - in_last=1 exactly on the FRAME_LEN-th sample.
  - On the last handshake: frame_count+1 (wraps), wr_idx=0, return to FILL. s_ready is high on the next cycle.
- Latency: config_valid rises 1 cycle after the closing s handshake. in_valid rises 1 cycle after the config handshake, or 1 cycle after close when config is skipped.
- Throughput: with in_ready held high, one sample per cycle.
- in_ready low for any duration stalls without data loss.
- Upstream samples offered during CONFIG/DRAIN are not accepted (no ping-pong). dir and reverse_order changes outside frame close have no effect.
- Index width: IDX_W=$clog2(FRAME_LEN). Indices never wrap mid-frame.

Decomposition:
- Package fft_seq_pkg holds:
  - state_t enum {FILL, CONFIG, DRAIN}
  - CFG_FWD=1, CFG_INV=0
  - function to build config_data from dir
- One natural sub-module: fft_frame_buffer (parametrised DATA_W x FRAME_LEN register array with a per-entry valid mask, clear-all, write port, combinational read).

Test Plan:
- Forward frame, FRAME_LEN=16, samples 0x25..., 0x3F3E3EBD, ..., in_ready=1 -> one config 0x01, 16 in_data in write order, in_last only on the 16th, frame_count=1.
- reverse_order=1, same samples -> in_data order is index 15..0, and the first output equals the last input written.
- in_ready toggled 1-0-0-1 pseudo-randomly -> no duplicated or dropped samples; in_data/in_last stable during stalls; order matches the model.
- s_last on the 5th sample -> frame_err pulses once; samples 6..16 out as 0; in_last still on the 16th output.
- CFG_EVERY_FRAME=0: frame 1 dir=1, frame 2 dir=1, frame 3 dir=0 -> config transactions only before frames 1 (0x01) and 3 (0x00).
- config_ready held low 20 cycles, then reset asserted mid-DRAIN -> config_valid holds for the 20 cycles; after reset all outputs return to reset values, and the next frame plays normally with frame_count counting from 0.
